alu_flag_branch_unit: RTL and testbench

- Consumer end of the ALU result/flag interface.
- Latches the ALU's [Z,V,N] flags into an architectural flag register, gated by opcode class.
- Resolves conditional branches against those flags, with same-cycle forwarding.
- Generates a registered PC redirect plus a timed pipeline flush; sits between the execute stage and fetch/decode.

---
 rtl/alu_flag_branch_unit_if.sv | 42 ++++
 rtl/alu_flag_branch_unit.sv | 113 +++++++++++
 tb/tb_alu_flag_branch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_flag_branch_unit_if.sv
// ---------------------------------------------------------------------------
// alu_flag_branch_unit_if
// Bundles the ALU result/flag inputs, the branch request inputs and the
// redirect/flush outputs of alu_flag_branch_unit.
//
// Signalling: every request signal is a plain per-cycle valid with no
// back-pressure. alu_done qualifies alu_op/alu_flags/flag_wr_en for the
// cycle it is high, and br_valid qualifies br_cond/br_target. There is no
// ready; while flush is high the unit drops both kinds of request silently.
// br_taken is a one-cycle valid for redirect_pc.
//
// modport slave  : the unit itself (consumes requests, drives results)
// modport master : the execute stage / testbench side
// ---------------------------------------------------------------------------
interface alu_flag_branch_unit_if #(
    parameter int DATA_W = 16
);
    logic              alu_done;
    logic [2:0]        alu_op;
    logic [2:0]        alu_flags;
    logic              flag_wr_en;
    logic              br_valid;
    logic [2:0]        br_cond;
    logic [DATA_W-1:0] br_target;
    logic [2:0]        flags_q;
    logic              br_taken;
    logic [DATA_W-1:0] redirect_pc;
    logic              flush;
    logic              busy;

    modport slave (
        input  alu_done, alu_op, alu_flags, flag_wr_en,
        input  br_valid, br_cond, br_target,
        output flags_q, br_taken, redirect_pc, flush, busy
    );

    modport master (
        output alu_done, alu_op, alu_flags, flag_wr_en,
        output br_valid, br_cond, br_target,
        input  flags_q, br_taken, redirect_pc, flush, busy
    );
endinterface

// File: rtl/alu_flag_branch_unit.sv
// ---------------------------------------------------------------------------
// alu_flag_branch_unit
// Consumer end of the ALU result/flag path. Holds the architectural [Z,V,N]
// flag register, resolves conditional branches against the flags the
// register is about to take (same-cycle forwarding), and produces a
// registered PC redirect plus a timed pipeline flush.
//
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_flag_branch_unit_if.slave
//            in  : alu_done, alu_op, alu_flags, flag_wr_en,
//                  br_valid, br_cond, br_target
//            out : flags_q [Z,V,N], br_taken, redirect_pc, flush, busy
// ---------------------------------------------------------------------------
module alu_flag_branch_unit #(
    parameter int DATA_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_flag_branch_unit_if.slave  bus
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;

    localparam logic [2:0] CC_NEQ  = 3'b000;
    localparam logic [2:0] CC_EQ   = 3'b001;
    localparam logic [2:0] CC_GT   = 3'b010;
    localparam logic [2:0] CC_LT   = 3'b011;
    localparam logic [2:0] CC_GTE  = 3'b100;
    localparam logic [2:0] CC_LTE  = 3'b101;
    localparam logic [2:0] CC_OVFL = 3'b110;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [2:0]        r_flags;
    logic              r_br_taken;
    logic [DATA_W-1:0] r_redirect_pc;
    logic [2:0]        r_flush_cnt;

    logic              w_flush;
    logic              w_wr;
    logic [2:0]        w_fwd;
    logic              w_cond;
    logic              w_take;

    assign w_flush = (r_flush_cnt != 3'd0);
    // Squashed ALU ops (flush high) never touch the flags.
    assign w_wr    = bus.alu_done & bus.flag_wr_en & ~w_flush;

    // w_fwd is exactly what r_flags loads at the next edge, so a branch in
    // the same cycle as a flag-writing op sees the new flags.
    always_comb begin
        w_fwd = r_flags;
        if (w_wr) begin
            unique case (bus.alu_op)
                OP_ADD, OP_SUB, OP_INC: w_fwd = bus.alu_flags;
                OP_NAND, OP_XOR:        w_fwd = {bus.alu_flags[2], r_flags[1:0]};
                default:                w_fwd = r_flags; // shifts leave flags alone
            endcase
        end
    end

    // Condition evaluation on forwarded flags: [2]=Z [1]=V [0]=N.
    always_comb begin
        w_cond = 1'b0;
        unique case (bus.br_cond)
            CC_NEQ:  w_cond = ~w_fwd[2];
            CC_EQ:   w_cond =  w_fwd[2];
            CC_GT:   w_cond = ~w_fwd[2] & ~w_fwd[0];
            CC_LT:   w_cond =  w_fwd[0];
            CC_GTE:  w_cond =  w_fwd[2] | ~w_fwd[0];
            CC_LTE:  w_cond =  w_fwd[0] |  w_fwd[2];
            CC_OVFL: w_cond =  w_fwd[1];
            default: w_cond = 1'b1;      // UNCOND
        endcase
    end

    // Branches arriving during a flush belong to squashed instructions.
    assign w_take = bus.br_valid & ~w_flush & w_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags       <= 3'b000;
            r_br_taken    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush_cnt   <= 3'd0;
        end else begin
            r_flags    <= w_fwd;
            r_br_taken <= w_take;
            if (w_take) begin
                r_redirect_pc <= bus.br_target;
            end
            // A take can only happen with the counter at zero, so the load
            // never collides with an in-progress countdown.
            if (w_take) begin
                r_flush_cnt <= FLUSH_LOAD;
            end else if (r_flush_cnt != 3'd0) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

    assign bus.flags_q     = r_flags;
    assign bus.br_taken    = r_br_taken;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.flush       = w_flush;
    assign bus.busy        = w_flush;
endmodule

// File: tb/tb_alu_flag_branch_unit.sv
module tb_alu_flag_branch_unit;
    localparam int DATA_W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_flag_branch_unit_if #(.DATA_W(DATA_W)) bus ();

    alu_flag_branch_unit #(.DATA_W(DATA_W), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs/outputs are touched 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_done   = 1'b0;
        bus.alu_op     = 3'b000;
        bus.alu_flags  = 3'b000;
        bus.flag_wr_en = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_cond    = 3'b000;
        bus.br_target  = '0;
    endtask

    task automatic drive_alu(input logic [2:0] op, input logic [2:0] fl);
        bus.alu_done   = 1'b1;
        bus.alu_op     = op;
        bus.alu_flags  = fl;
        bus.flag_wr_en = 1'b1;
    endtask

    task automatic drive_br(input logic [2:0] cc, input logic [15:0] tgt);
        bus.br_valid  = 1'b1;
        bus.br_cond   = cc;
        bus.br_target = tgt;
    endtask

    // Independent condition table: f = {Z,V,N}.
    function automatic logic cond_model(input logic [2:0] cc, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (cc)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle();
        step();
        step();
        chk("rst_flags",    32'(bus.flags_q), 32'h0);
        chk("rst_taken",    32'(bus.br_taken), 32'h0);
        chk("rst_redirect", 32'(bus.redirect_pc), 32'h0);
        chk("rst_flush",    32'(bus.flush), 32'h0);
        chk("rst_busy",     32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        step();

        // ADD loads all flags, XOR only Z.
        drive_alu(3'b000, 3'b101);
        step();
        idle();
        chk("add_flags", 32'(bus.flags_q), 32'h5);
        drive_alu(3'b011, 3'b010);
        step();
        idle();
        chk("xor_flags", 32'(bus.flags_q), 32'h1);

        // Clear flags, then flag write + dependent EQ branch in one cycle.
        drive_alu(3'b001, 3'b000);
        step();
        chk("sub_clear", 32'(bus.flags_q), 32'h0);
        drive_alu(3'b000, 3'b100);
        drive_br(3'b001, 16'h0040);
        step();
        idle();
        chk("fwd_taken",    32'(bus.br_taken), 32'h1);
        chk("fwd_redirect", 32'(bus.redirect_pc), 32'h0040);
        chk("fwd_flush1",   32'(bus.flush), 32'h1);
        chk("fwd_busy1",    32'(bus.busy), 32'h1);
        chk("fwd_flags",    32'(bus.flags_q), 32'h4);
        step();
        chk("fwd_pulse",    32'(bus.br_taken), 32'h0);
        chk("fwd_flush2",   32'(bus.flush), 32'h1);
        step();
        chk("fwd_flush3",   32'(bus.flush), 32'h0);
        chk("fwd_busy3",    32'(bus.busy), 32'h0);

        // OVFL taken with V=1, not taken with V=0.
        drive_alu(3'b000, 3'b010);
        step();
        idle();
        drive_br(3'b110, 16'h1234);
        step();
        idle();
        chk("ovfl_taken",    32'(bus.br_taken), 32'h1);
        chk("ovfl_redirect", 32'(bus.redirect_pc), 32'h1234);
        step();
        step();
        drive_alu(3'b000, 3'b000);
        step();
        idle();
        drive_br(3'b110, 16'h5678);
        step();
        idle();
        chk("ovfl_nt_taken",    32'(bus.br_taken), 32'h0);
        chk("ovfl_nt_flush",    32'(bus.flush), 32'h0);
        chk("ovfl_nt_redirect", 32'(bus.redirect_pc), 32'h1234);

        // Taken UNCOND, then squashed branch + SUB during the flush.
        drive_br(3'b111, 16'h0100);
        step();
        chk("unc_taken", 32'(bus.br_taken), 32'h1);
        drive_br(3'b111, 16'h0200);
        drive_alu(3'b001, 3'b111);
        step();
        chk("sq1_taken",    32'(bus.br_taken), 32'h0);
        chk("sq1_redirect", 32'(bus.redirect_pc), 32'h0100);
        chk("sq1_flags",    32'(bus.flags_q), 32'h0);
        chk("sq1_flush",    32'(bus.flush), 32'h1);
        step();
        idle();
        chk("sq2_taken",    32'(bus.br_taken), 32'h0);
        chk("sq2_redirect", 32'(bus.redirect_pc), 32'h0100);
        chk("sq2_flags",    32'(bus.flags_q), 32'h0);
        chk("sq2_flush",    32'(bus.flush), 32'h0);
        // First cycle after the flush: evaluated normally.
        drive_br(3'b000, 16'h0300);
        step();
        idle();
        chk("post_taken",    32'(bus.br_taken), 32'h1);
        chk("post_redirect", 32'(bus.redirect_pc), 32'h0300);
        chk("post_flush",    32'(bus.flush), 32'h1);
        step();
        step();

        // Shift op never writes flags.
        drive_alu(3'b111, 3'b111);
        step();
        idle();
        chk("sll_flags", 32'(bus.flags_q), 32'h0);

        // Condition sweep: 8 flag values x 8 codes.
        for (int f = 0; f < 8; f++) begin
            drive_alu(3'b000, 3'(f));
            step();
            idle();
            chk($sformatf("sweep_flags_f%0d", f), 32'(bus.flags_q), 32'(f));
            for (int c = 0; c < 8; c++) begin
                logic exp_t;
                exp_t = cond_model(3'(c), 3'(f));
                drive_br(3'(c), 16'(16'hA000 + f * 8 + c));
                step();
                idle();
                chk($sformatf("sweep_f%0d_c%0d", f, c), 32'(bus.br_taken), 32'(exp_t));
                if (exp_t) begin
                    step();
                    step();
                end
            end
        end

        // Async reset while the flush counter is 1.
        drive_alu(3'b000, 3'b111);
        step();
        idle();
        drive_br(3'b111, 16'hFFFF);
        step();
        idle();
        chk("pre_rst_redirect", 32'(bus.redirect_pc), 32'hFFFF);
        step();
        chk("pre_rst_flush", 32'(bus.flush), 32'h1);
        chk("pre_rst_flags", 32'(bus.flags_q), 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_flush",    32'(bus.flush), 32'h0);
        chk("async_busy",     32'(bus.busy), 32'h0);
        chk("async_taken",    32'(bus.br_taken), 32'h0);
        chk("async_flags",    32'(bus.flags_q), 32'h0);
        chk("async_redirect", 32'(bus.redirect_pc), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("after_rst_flush", 32'(bus.flush), 32'h0);
        step();
        chk("after_rst_flush2", 32'(bus.flush), 32'h0);
        chk("after_rst_taken",  32'(bus.br_taken), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
